// File: rtl/key_access_if.sv
// Request/acknowledge bundle shared by the processor bus and the crypto engine
// on their way to the key register controller.
interface key_access_if;
  logic bus_req;
  logic bus_we;
  logic bus_ack;
  logic bus_err;
  logic core_req;
  logic core_we;
  logic core_ack;

  modport master (output bus_req, bus_we, core_req, core_we,
                  input  bus_ack, bus_err, core_ack);
  modport slave  (input  bus_req, bus_we, core_req, core_we,
                  output bus_ack, bus_err, core_ack);
endinterface

// File: rtl/key_access_ctrl.sv
// Arbitrates bus/engine access to the 16-bit key register and issues its strobes.
// Optional bus-read lock is compiled in with `define KEY_ACCESS_CTRL_LOCK_EN.
module key_access_ctrl #(
  parameter int unsigned MAX_CORE_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  key_access_if.slave  kif,
  input  logic         lock_set,
  output logic         save_key_bus,
  output logic         send_key_bus,
  output logic         get_key,
  output logic         send_key,
  output logic         busy,
  output logic         key_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  localparam logic [3:0] MAXC = 4'(MAX_CORE_BURST);

  state_t     state_q, state_d;
  logic [3:0] core_cnt_q, core_cnt_d;
  logic       last_grant_q, last_grant_d;  // 1 = bus owns the current access
  logic       we_q, we_d;
  logic       refuse_q, refuse_d;
  logic [3:0] strb_q, strb_d;              // {save_key_bus, send_key_bus, get_key, send_key}
  logic       bus_ack_q, bus_ack_d;
  logic       bus_err_q, bus_err_d;
  logic       core_ack_q, core_ack_d;
  logic       busy_q, busy_d;
  logic       key_valid_q, key_valid_d;
  logic       lock_now;
  logic       grant_bus;

`ifdef KEY_ACCESS_CTRL_LOCK_EN
  logic locked_q, locked_d;
  assign locked_d = locked_q | lock_set;
  assign lock_now = locked_q;
  always_ff @(posedge clk) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end
`else
  logic lock_unused;
  assign lock_unused = lock_set;
  assign lock_now    = 1'b0;
`endif

  // Bus wins only when alone or once the core has used up its burst allowance.
  assign grant_bus = kif.bus_req && (!kif.core_req || core_cnt_q == MAXC);

  always_comb begin
    state_d      = state_q;
    core_cnt_d   = core_cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    refuse_d     = refuse_q;
    strb_d       = 4'b0000;
    bus_ack_d    = 1'b0;
    bus_err_d    = 1'b0;
    core_ack_d   = 1'b0;
    key_valid_d  = key_valid_q;
    case (state_q)
      IDLE: begin
        if (!kif.bus_req)  core_cnt_d = 4'd0;
        else if (grant_bus) core_cnt_d = 4'd0;
        else if (kif.core_req && core_cnt_q != MAXC) core_cnt_d = core_cnt_q + 4'd1;
        if (kif.bus_req || kif.core_req) begin
          state_d      = ISSUE;
          last_grant_d = grant_bus;
          we_d         = grant_bus ? kif.bus_we : kif.core_we;
          refuse_d     = grant_bus && !kif.bus_we && lock_now;
          if (grant_bus) strb_d = kif.bus_we ? 4'b1000 : (lock_now ? 4'b0000 : 4'b0100);
          else           strb_d = kif.core_we ? 4'b0010 : 4'b0001;
        end
      end
      ISSUE: begin
        state_d    = ACK;
        bus_ack_d  = last_grant_q;
        bus_err_d  = last_grant_q && refuse_q;
        core_ack_d = !last_grant_q;
      end
      ACK: begin
        state_d     = IDLE;
        key_valid_d = key_valid_q | we_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      core_cnt_q   <= 4'd0;
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      refuse_q     <= 1'b0;
      strb_q       <= 4'b0000;
      bus_ack_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      core_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_cnt_q   <= core_cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      refuse_q     <= refuse_d;
      strb_q       <= strb_d;
      bus_ack_q    <= bus_ack_d;
      bus_err_q    <= bus_err_d;
      core_ack_q   <= core_ack_d;
      busy_q       <= busy_d;
      key_valid_q  <= key_valid_d;
    end
  end

  assign {save_key_bus, send_key_bus, get_key, send_key} = strb_q;
  assign kif.bus_ack  = bus_ack_q;
  assign kif.bus_err  = bus_err_q;
  assign kif.core_ack = core_ack_q;
  assign busy         = busy_q;
  assign key_valid    = key_valid_q;
endmodule

// File: tb/tb_key_access_ctrl.sv
// Directed bench for key_access_ctrl with a behavioural key register on the strobes.
module tb_key_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock_set = 1'b0;
  logic save_key_bus, send_key_bus, get_key, send_key, busy, key_valid;
  logic [15:0] bus_din = 16'h0, core_din = 16'h0;
  logic [15:0] key_reg, key_out, key_outbus;
  int checks = 0;
  int errors = 0;

  key_access_if kif();

  key_access_ctrl #(.MAX_CORE_BURST(4)) dut (
    .clk(clk), .rst(rst), .kif(kif), .lock_set(lock_set),
    .save_key_bus(save_key_bus), .send_key_bus(send_key_bus),
    .get_key(get_key), .send_key(send_key),
    .busy(busy), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Key register model: writes on save/get, registered read ports on send strobes.
  always @(posedge clk) begin
    if (rst) begin
      key_reg <= 16'h0; key_out <= 16'h0; key_outbus <= 16'h0;
    end else begin
      if (save_key_bus) key_reg <= bus_din;
      if (get_key)      key_reg <= core_din;
      if (send_key)     key_out <= key_reg;
      if (send_key_bus) key_outbus <= key_reg;
    end
  end

  // Observed vector: {save_key_bus, send_key_bus, get_key, send_key, bus_ack, bus_err, core_ack, busy, key_valid}
  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {save_key_bus, send_key_bus, get_key, send_key,
           kif.bus_ack, kif.bus_err, kif.core_ack, busy, key_valid};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    kif.bus_req = 1'b0; kif.bus_we = 1'b0; kif.core_req = 1'b0; kif.core_we = 1'b0;
    step(); step();
    chk("reset_state", 9'b0000_000_0_0);
    rst = 1'b0;

    // bus write 0x1234
    kif.bus_req = 1'b1; kif.bus_we = 1'b1; bus_din = 16'h1234;
    step(); chk("bw_c1", 9'b1000_000_1_0);
    step(); chk("bw_c2", 9'b0000_100_1_0); kif.bus_req = 1'b0;
    step(); chk("bw_c3", 9'b0000_000_0_1);

    // core write 0xA5C3
    kif.core_req = 1'b1; kif.core_we = 1'b1; core_din = 16'hA5C3;
    step(); chk("cw_c1", 9'b0010_000_1_1);
    step(); chk("cw_c2", 9'b0000_001_1_1); kif.core_req = 1'b0;
    step(); chk("cw_c3", 9'b0000_000_0_1);

    // core read
    kif.core_req = 1'b1; kif.core_we = 1'b0;
    step(); chk("cr_c1", 9'b0001_000_1_1);
    step(); chk("cr_c2", 9'b0000_001_1_1); chk16("cr_key_out", key_out, 16'hA5C3);
    kif.core_req = 1'b0;
    step(); chk("cr_c3", 9'b0000_000_0_1);

    // bus read
    kif.bus_req = 1'b1; kif.bus_we = 1'b0;
    step(); chk("br_c1", 9'b0100_000_1_1);
    step(); chk("br_c2", 9'b0000_100_1_1); chk16("br_key_outbus", key_outbus, 16'hA5C3);
    kif.bus_req = 1'b0;
    step(); chk("br_c3", 9'b0000_000_0_1);

    // contention: both held, burst of 4 core then 1 bus, repeating
    kif.bus_req = 1'b1; kif.bus_we = 1'b0; kif.core_req = 1'b1; kif.core_we = 1'b0;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) begin
        step(); chk($sformatf("cont%0d_c1_bus", g), 9'b0100_000_1_1);
        step(); chk($sformatf("cont%0d_c2_bus", g), 9'b0000_100_1_1);
      end else begin
        step(); chk($sformatf("cont%0d_c1_core", g), 9'b0001_000_1_1);
        step(); chk($sformatf("cont%0d_c2_core", g), 9'b0000_001_1_1);
      end
      step(); chk($sformatf("cont%0d_c3", g), 9'b0000_000_0_1);
      if (g == 9) begin kif.bus_req = 1'b0; kif.core_req = 1'b0; end
    end

    // reset during ISSUE aborts the access
    kif.bus_req = 1'b1; kif.bus_we = 1'b1; bus_din = 16'hFFFF;
    step(); chk("mr_issue", 9'b1000_000_1_1);
    rst = 1'b1; kif.bus_req = 1'b0;
    step(); chk("mr_reset", 9'b0000_000_0_0);
    rst = 1'b0;
    step(); chk("mr_no_ack", 9'b0000_000_0_0);

    // lock pulse then bus read of the unwritten key
    lock_set = 1'b1;
    step(); lock_set = 1'b0; kif.bus_req = 1'b1; kif.bus_we = 1'b0;
`ifdef KEY_ACCESS_CTRL_LOCK_EN
    step(); chk("lk_rd_c1", 9'b0000_000_1_0);
    step(); chk("lk_rd_c2", 9'b0000_110_1_0);
`else
    step(); chk("lk_rd_c1", 9'b0100_000_1_0);
    step(); chk("lk_rd_c2", 9'b0000_100_1_0); chk16("lk_key_outbus", key_outbus, 16'h0000);
`endif
    kif.bus_req = 1'b0;
    step(); chk("lk_rd_c3", 9'b0000_000_0_0);

    // bus write still succeeds after lock
    kif.bus_req = 1'b1; kif.bus_we = 1'b1; bus_din = 16'h5A5A;
    step(); chk("lk_wr_c1", 9'b1000_000_1_0);
    step(); chk("lk_wr_c2", 9'b0000_100_1_0); kif.bus_req = 1'b0;
    step(); chk("lk_wr_c3", 9'b0000_000_0_1);
    chk16("lk_wr_key_reg", key_reg, 16'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // One-hot-or-zero strobe invariant, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && !$onehot0({save_key_bus, send_key_bus, get_key, send_key})) begin
      errors++;
      $error("FAIL strobe_onehot observed=%b expected=onehot0",
             {save_key_bus, send_key_bus, get_key, send_key});
    end
  end
endmodule
